// File: rtl/wave_dma_sched.sv
// wave_dma_sched: slot scheduler, shared-ROM address mux and play/stop
// command sequencer for up to 8 wave sample players.
// Ports:
//   I_CLK, I_RSTn      clock, async active-low reset
//   I_CMD_*            command push (valid/ready), {stop, chan, addr}
//   O_H_CNT            16-slot interleave counter
//   I_CH_ADDR          per-channel ROM address, 17 bits per channel
//   O_ROM_ADDR         shared ROM address; I_ROM_DATA comes back from the ROM
//   O_CH_DATA          ROM data broadcast to every player
//   O_DMA_TRIG/STOP    per-channel trigger pulse and sticky stop level
//   O_DMA_ADDR         per-channel start address
module wave_dma_sched #(
    parameter int ROM_LAT     = 1,
    parameter int FIFO_DEPTH  = 4,
    parameter int TRIG_CYCLES = 16
) (
    input  logic         I_CLK,
    input  logic         I_RSTn,
    input  logic         I_CMD_VALID,
    output logic         O_CMD_READY,
    input  logic         I_CMD_STOP,
    input  logic [2:0]   I_CMD_CHAN,
    input  logic [16:0]  I_CMD_ADDR,
    output logic [3:0]   O_H_CNT,
    input  logic [135:0] I_CH_ADDR,
    output logic [16:0]  O_ROM_ADDR,
    input  logic [7:0]   I_ROM_DATA,
    output logic [7:0]   O_CH_DATA,
    output logic [7:0]   O_DMA_TRIG,
    output logic [7:0]   O_DMA_STOP,
    output logic [135:0] O_DMA_ADDR
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL      = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0]  TRIG_INIT = 8'(TRIG_CYCLES - 1);
    localparam logic [3:0]  LAT_OFS   = 4'(ROM_LAT - 1);

    logic [3:0]                  h_cnt_q, h_cnt_d, rom_slot;
    logic [16:0]                 rom_addr_q, rom_addr_d;
    logic [7:0][16:0]            ch_addr;
    logic [FIFO_DEPTH-1:0][20:0] mem_q, mem_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [AW:0]                 count_q, count_d;
    logic [7:0]                  trig_q, trig_d;
    logic [7:0]                  stop_q, stop_d;
    logic [7:0][7:0]             tcnt_q, tcnt_d;
    logic [7:0][16:0]            dma_addr_q, dma_addr_d;
    logic [20:0]                 head;
    logic                        push, pop;

    assign ch_addr     = I_CH_ADDR;
    assign O_H_CNT     = h_cnt_q;
    assign O_ROM_ADDR  = rom_addr_q;
    assign O_CH_DATA   = I_ROM_DATA;
    assign O_DMA_TRIG  = trig_q;
    assign O_DMA_STOP  = stop_q;
    assign O_DMA_ADDR  = dma_addr_q;
    assign O_CMD_READY = (count_q != FULL);

    assign head = mem_q[rd_ptr_q];
    assign push = I_CMD_VALID & O_CMD_READY;
    // A play at the head waits for its channel's trigger to fall;
    // everything behind it waits too, keeping strict order.
    assign pop  = (count_q != '0) && (head[20] || !trig_q[head[19:17]]);

    // Issue channel c's address ROM_LAT slots ahead of its read slot {c,1}:
    // shifting the entered slot by ROM_LAT-1 maps the issue slot onto 2c.
    always_comb begin
        h_cnt_d    = h_cnt_q + 4'd1;
        rom_slot   = h_cnt_d + LAT_OFS;
        rom_addr_d = rom_addr_q;
        if (!rom_slot[0]) begin
            rom_addr_d = ch_addr[rom_slot[3:1]];
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {I_CMD_STOP, I_CMD_CHAN, I_CMD_ADDR};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        trig_d     = trig_q;
        stop_d     = stop_q;
        tcnt_d     = tcnt_q;
        dma_addr_d = dma_addr_q;
        for (int c = 0; c < 8; c++) begin
            if (trig_q[c]) begin
                if (tcnt_q[c] != 8'd0) begin
                    tcnt_d[c] = tcnt_q[c] - 8'd1;
                end else begin
                    trig_d[c] = 1'b0;
                end
            end
        end
        // A play only pops when its trigger is low, so it never collides
        // with the countdown above.
        if (pop) begin
            if (head[20]) begin
                stop_d[head[19:17]] = 1'b1;
            end else begin
                dma_addr_d[head[19:17]] = head[16:0];
                trig_d[head[19:17]]     = 1'b1;
                tcnt_d[head[19:17]]     = TRIG_INIT;
                stop_d[head[19:17]]     = 1'b0;
            end
        end
    end

    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            h_cnt_q    <= '0;
            rom_addr_q <= '0;
            mem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            trig_q     <= '0;
            stop_q     <= '0;
            tcnt_q     <= '0;
            dma_addr_q <= '0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            rom_addr_q <= rom_addr_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            trig_q     <= trig_d;
            stop_q     <= stop_d;
            tcnt_q     <= tcnt_d;
            dma_addr_q <= dma_addr_d;
        end
    end

endmodule

// File: tb/tb_wave_dma_sched.sv
// tb_wave_dma_sched: directed bench for wave_dma_sched; a ROM_LAT=1 instance
// runs all scenarios, a ROM_LAT=2 instance checks address/data alignment.
module tb_wave_dma_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid, cmd_stop;
    logic [2:0]   cmd_chan;
    logic [16:0]  cmd_addr;
    logic [135:0] ch_addr;

    logic         ready1, ready2;
    logic [3:0]   h1, h2;
    logic [16:0]  rom_addr1, rom_addr2;
    logic [7:0]   rom_data1, rom_data2, rom_r1;
    logic [7:0]   ch_data1, ch_data2;
    logic [7:0]   trig, stop, trig2, stop2;
    logic [135:0] dma_addr, dma_addr2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] romf(input logic [16:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    always_ff @(posedge clk) begin
        rom_data1 <= romf(rom_addr1);
        rom_r1    <= romf(rom_addr2);
        rom_data2 <= rom_r1;
    end

    wave_dma_sched #(.ROM_LAT(1)) dut (
        .I_CLK(clk), .I_RSTn(rst_n),
        .I_CMD_VALID(cmd_valid), .O_CMD_READY(ready1),
        .I_CMD_STOP(cmd_stop), .I_CMD_CHAN(cmd_chan),
        .I_CMD_ADDR(cmd_addr), .O_H_CNT(h1),
        .I_CH_ADDR(ch_addr), .O_ROM_ADDR(rom_addr1),
        .I_ROM_DATA(rom_data1), .O_CH_DATA(ch_data1),
        .O_DMA_TRIG(trig), .O_DMA_STOP(stop),
        .O_DMA_ADDR(dma_addr)
    );

    wave_dma_sched #(.ROM_LAT(2)) dut2 (
        .I_CLK(clk), .I_RSTn(rst_n),
        .I_CMD_VALID(1'b0), .O_CMD_READY(ready2),
        .I_CMD_STOP(cmd_stop), .I_CMD_CHAN(cmd_chan),
        .I_CMD_ADDR(cmd_addr), .O_H_CNT(h2),
        .I_CH_ADDR(ch_addr), .O_ROM_ADDR(rom_addr2),
        .I_ROM_DATA(rom_data2), .O_CH_DATA(ch_data2),
        .O_DMA_TRIG(trig2), .O_DMA_STOP(stop2),
        .O_DMA_ADDR(dma_addr2)
    );

    task automatic push(input logic s, input logic [2:0] c,
                        input logic [16:0] a);
        cmd_valid = 1'b1;
        cmd_stop  = s;
        cmd_chan  = c;
        cmd_addr  = a;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_stop  = 1'b0;
        cmd_chan  = 3'd0;
        cmd_addr  = '0;
        for (int c = 0; c < 8; c++) ch_addr[17*c +: 17] = 17'(256 + c);
        #12;
        total_cnt++;
        if (h1 !== 4'd0) $display("FAIL rst_hcnt got %h exp 0", h1);
        else pass_cnt++;
        total_cnt++;
        if (rom_addr1 !== 17'd0) $display("FAIL rst_romaddr got %h exp 0", rom_addr1);
        else pass_cnt++;
        total_cnt++;
        if (trig !== 8'd0 || stop !== 8'd0)
            $display("FAIL rst_trig_stop got %h/%h exp 0/0", trig, stop);
        else pass_cnt++;
        total_cnt++;
        if (dma_addr !== 136'd0) $display("FAIL rst_dma_addr got %h exp 0", dma_addr);
        else pass_cnt++;
        total_cnt++;
        if (ready1 !== 1'b1) $display("FAIL rst_ready got %b exp 1", ready1);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_slots;
        int exp_h = 0;
        logic [16:0] e;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            exp_h = (exp_h + 1) % 16;
            total_cnt++;
            if (h1 !== 4'(exp_h)) $display("FAIL slot_hcnt got %0d exp %0d", h1, exp_h);
            else pass_cnt++;
            if (i >= 16) begin
                if (exp_h % 2 == 0) begin
                    e = 17'(256 + exp_h / 2);
                    total_cnt++;
                    if (rom_addr1 !== e)
                        $display("FAIL lat1_addr slot %0d got %h exp %h", exp_h, rom_addr1, e);
                    else pass_cnt++;
                end else begin
                    e = 17'(256 + exp_h / 2);
                    total_cnt++;
                    if (ch_data1 !== romf(e))
                        $display("FAIL lat1_data slot %0d got %h exp %h", exp_h, ch_data1, romf(e));
                    else pass_cnt++;
                    total_cnt++;
                    if (ch_data2 !== romf(e))
                        $display("FAIL lat2_data slot %0d got %h exp %h", exp_h, ch_data2, romf(e));
                    else pass_cnt++;
                    e = 17'(256 + (((exp_h + 1) / 2) % 8));
                    total_cnt++;
                    if (rom_addr2 !== e)
                        $display("FAIL lat2_addr slot %0d got %h exp %h", exp_h, rom_addr2, e);
                    else pass_cnt++;
                end
            end
        end
    endtask

    task automatic test_play;
        int n;
        push(1'b0, 3'd2, 17'h01234);
        total_cnt++;
        if (trig[2] !== 1'b0) $display("FAIL play_early got %b exp 0", trig[2]);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (trig[2] !== 1'b1) $display("FAIL play_rise got %b exp 1", trig[2]);
        else pass_cnt++;
        total_cnt++;
        if (dma_addr[34 +: 17] !== 17'h01234)
            $display("FAIL play_addr got %h exp 01234", dma_addr[34 +: 17]);
        else pass_cnt++;
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (trig[2]) n++;
            else break;
        end
        total_cnt++;
        if (n != 16) $display("FAIL play_width got %0d exp 16", n);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic c_early = 1'b0;
        logic fell    = 1'b0;
        cmd_valid = 1'b1; cmd_stop = 1'b0;
        cmd_chan = 3'd5; cmd_addr = 17'h05A5A;
        @(negedge clk);
        cmd_addr = 17'h05B5B;
        @(negedge clk);
        cmd_chan = 3'd1; cmd_addr = 17'h01C1C;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (trig[1] !== 1'b0) c_early = 1'b1;
            if (!trig[5]) begin
                fell = 1'b1;
                break;
            end
        end
        total_cnt++;
        if (!fell || c_early)
            $display("FAIL b2b_first got fell=%b c_early=%b exp 1/0", fell, c_early);
        else pass_cnt++;
        total_cnt++;
        if (dma_addr[85 +: 17] !== 17'h05A5A)
            $display("FAIL b2b_addr_a got %h exp 05a5a", dma_addr[85 +: 17]);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (trig[5] !== 1'b1 || trig[1] !== 1'b0)
            $display("FAIL b2b_second got t5=%b t1=%b exp 1/0", trig[5], trig[1]);
        else pass_cnt++;
        total_cnt++;
        if (dma_addr[85 +: 17] !== 17'h05B5B)
            $display("FAIL b2b_addr_b got %h exp 05b5b", dma_addr[85 +: 17]);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (trig[1] !== 1'b1 || dma_addr[17 +: 17] !== 17'h01C1C)
            $display("FAIL b2b_third got t1=%b a=%h exp 1/01c1c", trig[1], dma_addr[17 +: 17]);
        else pass_cnt++;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_fifo_full;
        logic [20:0] cmds [5];
        logic        rdy_bad = 1'b0;
        logic        fell    = 1'b0;
        cmds[0] = {1'b0, 3'd4, 17'h04444};
        cmds[1] = {1'b0, 3'd6, 17'h06666};
        cmds[2] = {1'b0, 3'd7, 17'h07777};
        cmds[3] = {1'b1, 3'd0, 17'h00000};
        cmds[4] = {1'b0, 3'd0, 17'h0BEEF};
        push(1'b0, 3'd4, 17'h04040);
        for (int k = 0; k < 5; k++) begin
            cmd_valid = 1'b1;
            {cmd_stop, cmd_chan, cmd_addr} = cmds[k];
            total_cnt++;
            if (ready1 !== (k < 4))
                $display("FAIL full_ready k=%0d got %b exp %b", k, ready1, k < 4);
            else pass_cnt++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ready1 !== 1'b0) rdy_bad = 1'b1;
            if (!trig[4]) begin
                fell = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total_cnt++;
        if (!fell || rdy_bad)
            $display("FAIL full_hold got fell=%b rdy_bad=%b exp 1/0", fell, rdy_bad);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (ready1 !== 1'b1 || trig[4] !== 1'b1)
            $display("FAIL full_pop got rdy=%b t4=%b exp 1/1", ready1, trig[4]);
        else pass_cnt++;
        total_cnt++;
        if (dma_addr[68 +: 17] !== 17'h04444)
            $display("FAIL full_addr4 got %h exp 04444", dma_addr[68 +: 17]);
        else pass_cnt++;
        repeat (60) @(negedge clk);
        total_cnt++;
        if (stop[0] !== 1'b1 || trig[0] !== 1'b0 || dma_addr[0 +: 17] !== 17'h0)
            $display("FAIL full_drop5 got s0=%b t0=%b a0=%h exp 1/0/0",
                     stop[0], trig[0], dma_addr[0 +: 17]);
        else pass_cnt++;
        total_cnt++;
        if (dma_addr[102 +: 17] !== 17'h06666 || dma_addr[119 +: 17] !== 17'h07777)
            $display("FAIL full_order got %h/%h exp 06666/07777",
                     dma_addr[102 +: 17], dma_addr[119 +: 17]);
        else pass_cnt++;
    endtask

    task automatic test_stop_reset;
        int   n;
        logic stop_lost = 1'b0;
        logic trig_bad  = 1'b0;
        cmd_valid = 1'b1; cmd_stop = 1'b0;
        cmd_chan = 3'd3; cmd_addr = 17'h03333;
        @(negedge clk);
        cmd_stop = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        total_cnt++;
        if (trig[3] !== 1'b1 || stop[3] !== 1'b0)
            $display("FAIL stop_pre got t=%b s=%b exp 1/0", trig[3], stop[3]);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (trig[3] !== 1'b1 || stop[3] !== 1'b1)
            $display("FAIL stop_set got t=%b s=%b exp 1/1", trig[3], stop[3]);
        else pass_cnt++;
        n = 2;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stop[3] !== 1'b1) stop_lost = 1'b1;
            if (trig[3]) n++;
            else break;
        end
        total_cnt++;
        if (n != 16 || stop_lost)
            $display("FAIL stop_width got %0d lost=%b exp 16/0", n, stop_lost);
        else pass_cnt++;
        push(1'b0, 3'd3, 17'h03A3A);
        total_cnt++;
        if (trig[3] !== 1'b0 || stop[3] !== 1'b1)
            $display("FAIL replay_pre got t=%b s=%b exp 0/1", trig[3], stop[3]);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (trig[3] !== 1'b1 || stop[3] !== 1'b0 || dma_addr[51 +: 17] !== 17'h03A3A)
            $display("FAIL replay got t=%b s=%b a=%h exp 1/0/03a3a",
                     trig[3], stop[3], dma_addr[51 +: 17]);
        else pass_cnt++;
        push(1'b0, 3'd3, 17'h03B3B);
        push(1'b0, 3'd6, 17'h06B6B);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (trig !== 8'd0 || stop !== 8'd0 || dma_addr !== 136'd0)
            $display("FAIL midrst_out got t=%h s=%h a=%h exp 0", trig, stop, dma_addr);
        else pass_cnt++;
        total_cnt++;
        if (h1 !== 4'd0 || rom_addr1 !== 17'd0 || ready1 !== 1'b1)
            $display("FAIL midrst_state got h=%h r=%h rdy=%b exp 0/0/1", h1, rom_addr1, ready1);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (trig !== 8'd0) trig_bad = 1'b1;
        end
        total_cnt++;
        if (trig_bad || dma_addr !== 136'd0)
            $display("FAIL midrst_flush got bad=%b a=%h exp 0/0", trig_bad, dma_addr);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_slots();
        test_play();
        test_back_to_back();
        test_fifo_full();
        test_stop_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/wave_dma_sched.md
Name: wave_dma_sched

Overview:
- Time-division scheduler and command sequencer for up to 8 wave_sound-style sample players that share one 8-bit wave ROM.
- Generates the 16-slot interleave counter and multiplexes each channel's ROM address into its slot. The ROM returns data in the slot where that channel's player samples it.
- Accepts play/stop commands through a small FIFO and converts them into per-channel trigger pulses, start addresses and stop levels.

Parameters:
- ROM_LAT, 1, ROM read latency in clocks; legal values 1 or 2.
- FIFO_DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- TRIG_CYCLES, 16, clocks that a trigger is held high; legal range 2..255.

Ports:
- I_CLK  in  1  system clock
- I_RSTn  in  1  asynchronous active-low reset
- I_CMD_VALID  in  1  command offered
- O_CMD_READY  out  1  FIFO can accept a command (= not full)
- I_CMD_STOP  in  1  1 = stop command, 0 = play command
- I_CMD_CHAN  in  3  target channel
- I_CMD_ADDR  in  17  play start address (ignored for stop)
- O_H_CNT  out  4  slot counter, fans out to every player's I_H_CNT
- I_CH_ADDR  in  136  per-channel ROM address; channel c occupies bits [17c+16:17c]
- O_ROM_ADDR  out  17  shared ROM address
- I_ROM_DATA  in  8  shared ROM data
- O_CH_DATA  out  8  broadcast ROM data = I_ROM_DATA (combinational)
- O_DMA_TRIG  out  8  per-channel trigger
- O_DMA_STOP  out  8  per-channel stop level
- O_DMA_ADDR  out  136  per-channel start address, same packing as I_CH_ADDR

Behaviour:
- Reset state (asynchronous, active-low): O_H_CNT=0, O_ROM_ADDR=0, O_DMA_TRIG=0, O_DMA_STOP=0, O_DMA_ADDR=0, FIFO empty, all trigger counters 0. O_CMD_READY=1.
- Slot counter:
  - O_H_CNT is registered and increments by 1 every clock, wrapping 15->0.
  - Channel c owns read slot {c,1}; its player samples O_CH_DATA on the clock edge that ends slot {c,1}.
- ROM address issue:
  - O_ROM_ADDR is registered. It loads I_CH_ADDR[c] on the edge entering slot s_c = (2c+1-ROM_LAT) mod 16, and holds otherwise.
  - ROM_LAT=1: channel 0 address is issued in slot 0. ROM_LAT=2: channel 0 address is issued in slot 15 of the previous frame.
  - In both cases I_ROM_DATA for channel c is valid throughout slot {c,1}.
  - Each channel address is sampled once per 16-clock frame.
- Command FIFO:
  - Each entry is {stop, chan, addr}. A push occurs on I_CMD_VALID & O_CMD_READY.
  - Push and pop in the same cycle are legal; occupancy is unchanged.
  - A push into an empty FIFO becomes eligible for dispatch on the next clock.
- Dispatch:
  - At most one command per clock, always from the FIFO head, strictly in order (no reordering).
  - Stop at the head: dispatched immediately. Sets O_DMA_STOP[chan]=1, which stays sticky. Does not alter an active trigger.
  - Play at the head: dispatched only when O_DMA_TRIG[chan]=0. Otherwise the head blocks, and commands for other channels wait behind it.
  - On play dispatch, in the same edge:
    - O_DMA_ADDR[chan] <= addr
    - O_DMA_TRIG[chan] <= 1
    - trigger counter <= TRIG_CYCLES-1
    - O_DMA_STOP[chan] <= 0
- Trigger counter (per channel):
  - While the trigger is high and the counter is >0, decrement.
  - When the trigger is high and the counter is 0, drop the trigger.
  - Result: the trigger is high for exactly TRIG_CYCLES clocks, then low for at least 1 clock before any re-rise, which guarantees a clean rising edge to the player.
- O_DMA_ADDR[c] holds its value until the next play dispatch to channel c.
- Reset asserted mid-operation: all state returns to reset values immediately and asynchronously, and queued commands are discarded.

Test Plan:
1. Reset release with ROM_LAT=1 and I_CH_ADDR[c]=0x100+c -> O_H_CNT runs 0..15 and wraps. O_ROM_ADDR=0x100+c during slot 2c. A ROM model with 1-clock latency returns data readable in slot 2c+1 for every channel.
2. Same as scenario 1 with ROM_LAT=2 -> channel 0 address is issued in slot 15 and channel 3 address in slot 5. Data alignment in slot {c,1} is unchanged.
3. Play chan 2, addr 0x01234 -> O_DMA_ADDR[2]=0x01234 and O_DMA_TRIG[2] is high for exactly 16 clocks, starting 1 clock after the push into an empty FIFO.
4. Back-to-back play chan 5 then play chan 5 -> the second trigger rises on the second clock after the first trigger falls (1 low cycle). A play chan 1 queued behind them waits in order.
5. Push 5 commands while a head play is blocked -> O_CMD_READY=0 after 4 entries and the 5th push is not accepted. READY returns to 1 on the first pop.
6. Stop chan 3 while O_DMA_TRIG[3] is active -> O_DMA_STOP[3]=1 immediately and the trigger completes its 16 clocks. A later play chan 3 clears STOP on the same edge the trigger rises. Asserting reset mid-stream clears all outputs.
